// File: rtl/div_sequencer_if.sv
// Request/result bundle for the iterative divider.
// master: the requester (ALU/mainfsm side); slave: the divider.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, flush, is_signed, dividend, divisor,
    input  busy, stall, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, flush, is_signed, dividend, divisor,
    output busy, stall, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider with its own sequencing FSM.
// IDLE -> PREP (abs values) -> ITER x WIDTH -> FIX (sign) -> DONE.
// Divide-by-zero short-cuts PREP -> DONE with all-ones quotient.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  div_sequencer_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state, nxt;
  logic [CW-1:0]    cnt;

  // operands as captured on the accepted start
  logic [WIDTH-1:0] a_raw, b_raw;
  logic             sgn;

  // working registers: num ends up holding the unsigned quotient
  logic [WIDTH-1:0] num, den, rem;
  logic             q_neg, r_neg;

  // architectural results
  logic [WIDTH-1:0] quo_q, rem_q;
  logic             dbz_q;

  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, trial;
  logic             trial_ok;

  assign accept = bus.start & ~bus.flush & ((state == IDLE) | (state == DONE));
  assign b_zero = (b_raw == '0);

  // magnitude only matters for signed operands; unsigned pass straight through
  assign a_abs = (sgn & a_raw[WIDTH-1]) ? -a_raw : a_raw;
  assign b_abs = (sgn & b_raw[WIDTH-1]) ? -b_raw : b_raw;

  // one restoring step: rem < den always holds, so WIDTH+1 bits hold the trial
  assign rem_sh   = {rem, num[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, den};
  assign trial_ok = ~trial[WIDTH];

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic; flush overrides everything, including start
  always_comb begin
    nxt = state;
    if (bus.flush) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) nxt = PREP;
        PREP:    nxt = b_zero ? DONE : ITER;
        ITER:    if (cnt == '0) nxt = FIX;
        FIX:     nxt = DONE;
        DONE:    nxt = bus.start ? PREP : IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  // status outputs decoded from state
  always_comb begin
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      PREP, ITER, FIX: bus.busy = 1'b1;
      DONE:            bus.done = 1'b1;
      default:         ;
    endcase
    bus.stall = bus.busy;
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

  // datapath: operand capture, prep, shift/subtract steps and sign fix-up
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      a_raw <= '0;
      b_raw <= '0;
      sgn   <= 1'b0;
      num   <= '0;
      den   <= '0;
      rem   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      if (accept) begin
        a_raw <= bus.dividend;
        b_raw <= bus.divisor;
        sgn   <= bus.is_signed;
        dbz_q <= 1'b0;
      end
      // a flushed operation must not touch the held results
      if (!bus.flush) begin
        case (state)
          PREP: begin
            num   <= a_abs;
            den   <= b_abs;
            rem   <= '0;
            q_neg <= sgn & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
            r_neg <= sgn & a_raw[WIDTH-1];
            cnt   <= CW'(WIDTH - 1);
            if (b_zero) begin
              quo_q <= '1;
              rem_q <= a_raw;
              dbz_q <= 1'b1;
            end
          end
          ITER: begin
            num <= {num[WIDTH-2:0], trial_ok};
            rem <= trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            cnt <= cnt - CW'(1);
          end
          FIX: begin
            quo_q <= q_neg ? -num : num;
            rem_q <= r_neg ? -rem : rem;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: the driver queues expected results and
// completion cycle, a negedge monitor pops and compares on every done pulse.
module tb_div_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           c;
  } exp_t;

  exp_t sbq[$];

  div_sequencer_if #(.WIDTH(W)) bus ();

  div_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        automatic exp_t e = sbq.pop_front();
        chk("quotient",    64'(bus.quotient),    64'(e.q));
        chk("remainder",   64'(bus.remainder),   64'(e.r));
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(e.z));
        chk("done_cycle",  64'(cyc),             64'(e.c));
      end
    end
  end

  // drive one request at a negedge; it is accepted at the following posedge
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.dividend  = a;
    bus.divisor   = b;
    e.q = q;
    e.r = r;
    e.z = z;
    e.c = cyc + 1 + ((b == '0) ? 1 : W + 2);
    sbq.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // bounded wait for done; reports the number of busy cycles seen on the way
  task automatic wait_done(output int nb);
    int mis = 0;
    int i = 0;
    logic got = 1'b0;
    nb = 0;
    while (i < 200 && !got) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bus.busy === 1'b1) nb++;
        if (bus.stall !== bus.busy) mis++;
        @(negedge clk);
        i++;
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("stall_eq_busy_mismatches", 64'(mis), 64'd0);
  endtask

  task automatic run(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    int nb;
    issue(s, a, b, q, r, z);
    wait_done(nb);
  endtask

  initial begin
    int nb;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_q",     64'(bus.quotient), 64'd0);
    chk("rst_r",     64'(bus.remainder), 64'd0);
    chk("rst_dbz",   64'(bus.div_by_zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // unsigned 100/7 from IDLE: 34 busy cycles then done
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    wait_done(nb);
    chk("busy_cycles", 64'(nb), 64'(W + 2));

    // signed cases, back-to-back from DONE
    run(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);

    // divide by zero: short latency
    issue(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    wait_done(nb);
    chk("dbz_busy_cycles", 64'(nb), 64'd1);

    // signed overflow; div_by_zero clears on the accepted start
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    chk("dbz_cleared", 64'(bus.div_by_zero), 64'd0);
    wait_done(nb);

    run(1'b1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
    run(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    run(1'b0, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0);
    run(1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    @(negedge clk);

    // start while busy is ignored; start in DONE is accepted
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    chk("held_q_while_busy", 64'(bus.quotient), 64'hFFFFFFF2);
    wait_done(nb);
    issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    chk("held_q_prev", 64'(bus.quotient), 64'd14);
    chk("held_r_prev", 64'(bus.remainder), 64'd2);
    wait_done(nb);

    // flush mid-ITER: back to IDLE, no done, results retained
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    sbq.delete();
    chk("flush_busy", 64'(bus.busy), 64'd0);
    chk("flush_done", 64'(bus.done), 64'd0);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_over_start", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush_keep_q", 64'(bus.quotient), 64'd3);
    chk("flush_keep_r", 64'(bus.remainder), 64'd0);

    // async reset mid-operation
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    repeat (12) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy",  64'(bus.busy), 64'd0);
    chk("arst_stall", 64'(bus.stall), 64'd0);
    chk("arst_done",  64'(bus.done), 64'd0);
    chk("arst_q",     64'(bus.quotient), 64'd0);
    chk("arst_r",     64'(bus.remainder), 64'd0);
    chk("arst_dbz",   64'(bus.div_by_zero), 64'd0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // normal operation after reset
    run(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute safety net against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
